// File: rtl/dmem_line_buffer.sv
// rtl/dmem_line_buffer.sv - single-line write-back buffer between 16-bit word accesses and a 256-bit line memory
module dmem_line_buffer #(
    parameter int LINE_AW = 12,
    parameter int WORD_W  = 16,
    parameter int WORDS   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_we,
    input  logic [LINE_AW+$clog2(WORDS)-1:0]      req_addr,
    input  logic [WORD_W-1:0]                     req_wdata,
    output logic                                  resp_valid,
    output logic [WORD_W-1:0]                     resp_rdata,
    input  logic                                  flush,
    output logic                                  flush_done,
    output logic                                  mem_wen,
    output logic [LINE_AW-1:0]                    mem_addr,
    output logic [WORDS*WORD_W-1:0]               mem_wdata,
    input  logic [WORDS*WORD_W-1:0]               mem_rdata
);
    localparam int IDX_W  = $clog2(WORDS);
    localparam int LINE_W = WORDS * WORD_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]         state;
    logic               valid_q;
    logic               dirty_q;
    logic [LINE_AW-1:0] tag_q;
    logic [WORD_W-1:0]  line_q [WORDS];

    logic               pend_we;
    logic               pend_flush;
    logic [LINE_AW-1:0] pend_line;
    logic [IDX_W-1:0]   pend_idx;
    logic [WORD_W-1:0]  pend_wdata;

    logic [LINE_AW-1:0] req_line;
    logic [IDX_W-1:0]   req_idx;
    logic               hit;
    logic [WORD_W-1:0]  fill_word [WORDS];

    assign req_line = req_addr[LINE_AW+IDX_W-1:IDX_W];
    assign req_idx  = req_addr[IDX_W-1:0];
    assign hit      = valid_q && (tag_q == req_line);

    // The cycle carrying a hit response also blocks acceptance, giving one accept per two cycles.
    assign req_ready = (state == S_IDLE) && !flush && !rst && !resp_valid;

    // Memory lanes are asymmetric: writes place word i low-first, reads deliver word i high-first.
    always_comb begin
        mem_wdata = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem_wdata[i*WORD_W +: WORD_W] = line_q[i];
            fill_word[i] = mem_rdata[LINE_W-1-i*WORD_W -: WORD_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            tag_q      <= '0;
            for (int i = 0; i < WORDS; i++) line_q[i] <= '0;
            pend_we    <= 1'b0;
            pend_flush <= 1'b0;
            pend_line  <= '0;
            pend_idx   <= '0;
            pend_wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            flush_done <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            resp_valid <= 1'b0;
            flush_done <= 1'b0;
            mem_wen    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        if (valid_q && dirty_q) begin
                            state      <= S_WB;
                            pend_flush <= 1'b1;
                            mem_wen    <= 1'b1;
                            mem_addr   <= tag_q;
                        end else begin
                            flush_done <= 1'b1;
                        end
                    end else if (req_valid && req_ready) begin
                        if (hit) begin
                            resp_valid <= 1'b1;
                            if (req_we) begin
                                line_q[req_idx] <= req_wdata;
                                dirty_q         <= 1'b1;
                                resp_rdata      <= req_wdata;
                            end else begin
                                resp_rdata <= line_q[req_idx];
                            end
                        end else begin
                            pend_we    <= req_we;
                            pend_flush <= 1'b0;
                            pend_line  <= req_line;
                            pend_idx   <= req_idx;
                            pend_wdata <= req_wdata;
                            if (valid_q && dirty_q) begin
                                state    <= S_WB;
                                mem_wen  <= 1'b1;
                                mem_addr <= tag_q;
                            end else begin
                                state    <= S_FILL;
                                mem_addr <= req_line;
                            end
                        end
                    end
                end
                S_WB: begin
                    dirty_q <= 1'b0;
                    if (pend_flush) begin
                        state      <= S_IDLE;
                        flush_done <= 1'b1;
                    end else begin
                        state    <= S_FILL;
                        mem_addr <= pend_line;
                    end
                end
                S_FILL: begin
                    for (int i = 0; i < WORDS; i++) line_q[i] <= fill_word[i];
                    if (pend_we) begin
                        line_q[pend_idx] <= pend_wdata;
                        dirty_q          <= 1'b1;
                        resp_rdata       <= pend_wdata;
                    end else begin
                        resp_rdata <= fill_word[pend_idx];
                    end
                    tag_q      <= pend_line;
                    valid_q    <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
